mem_port_arbiter: RTL and testbench

//  Shares one single-ported MEM (word memory: combinational read, write on CLK) between
//  two requesters: port 0 = instruction fetch, port 1 = data load/store. Enables a

---
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-ported word memory: fetch (port 0) and
// load/store (port 1) share it, port 1 has priority, and port 0 has a starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic              WE0,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [DATA_W-1:0] WDATA0,
    output logic              ACK0,
    output logic [DATA_W-1:0] RDATA0,
    input  logic              REQ1,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              ACK1,
    output logic [DATA_W-1:0] RDATA1,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [DATA_W-1:0] M_DIN,
    output logic              M_WE,
    input  logic [DATA_W-1:0] M_DOUT,
    output logic              BUSY
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic                winner_q, winner_d;   // 0 = port 0, 1 = port 1
    logic                m_we_q,   m_we_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_din_q,  m_din_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic [CNT_W-1:0]    starve_q, starve_d;
    logic                grant0;

    // NOTE: every signal gets its hold value first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        m_we_d   = m_we_q;
        m_addr_d = m_addr_q;
        m_din_d  = m_din_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        starve_d = starve_q;
        grant0   = 1'b0;

        case (state_q)
            IDLE: begin
                m_we_d = 1'b0;
                if (REQ0 || REQ1) begin
                    // Port 0 wins alone, or when port 1 has beaten it STARVE_MAX times in a row.
                    grant0   = REQ0 && (!REQ1 || (starve_q == STARVE_LIM));
                    winner_d = !grant0;
                    m_we_d   = grant0 ? WE0    : WE1;
                    m_addr_d = grant0 ? ADDR0  : ADDR1;
                    m_din_d  = grant0 ? WDATA0 : WDATA1;
                    starve_d = (REQ0 && REQ1 && !grant0) ? starve_q + CNT_W'(1) : '0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (!m_we_q) begin
                    if (winner_q) rdata1_d = M_DOUT;
                    else          rdata0_d = M_DOUT;
                end
                m_we_d  = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            winner_q <= 1'b0;
            m_we_q   <= 1'b0;
            m_addr_q <= '0;
            m_din_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            m_we_q   <= m_we_d;
            m_addr_q <= m_addr_d;
            m_din_q  <= m_din_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            starve_q <= starve_d;
        end
    end

    // ACKs decode straight from state so an async reset in RESP removes them at once.
    assign ACK0   = (state_q == RESP) && !winner_q;
    assign ACK1   = (state_q == RESP) &&  winner_q;
    assign BUSY   = (state_q != IDLE);
    assign M_WE   = m_we_q;
    assign M_ADDR = m_addr_q;
    assign M_DIN  = m_din_q;
    assign RDATA0 = rdata0_q;
    assign RDATA1 = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 16-word behavioural memory and an
// ACK scoreboard holding the expected port order and read data.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              CLK = 1'b0;
    logic              RST;
    logic              REQ0, WE0, REQ1, WE1;
    logic [ADDR_W-1:0] ADDR0, ADDR1;
    logic [DATA_W-1:0] WDATA0, WDATA1;
    logic              ACK0, ACK1, M_WE, BUSY;
    logic [DATA_W-1:0] RDATA0, RDATA1, M_DIN, M_DOUT;
    logic [ADDR_W-1:0] M_ADDR;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0), .ACK0(ACK0), .RDATA0(RDATA0),
        .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1), .ACK1(ACK1), .RDATA1(RDATA1),
        .M_ADDR(M_ADDR), .M_DIN(M_DIN), .M_WE(M_WE), .M_DOUT(M_DOUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Word memory: combinational read, write on the clock; tb preloads via the poke port.
    logic [DATA_W-1:0] mem [16];
    logic              poke_en = 1'b0;
    logic [3:0]        poke_idx = '0;
    logic [DATA_W-1:0] poke_data = '0;
    assign M_DOUT = mem[M_ADDR[5:2]];
    always @(posedge CLK) begin
        if (M_WE)         mem[M_ADDR[5:2]] <= M_DIN;
        else if (poke_en) mem[poke_idx]    <= poke_data;
    end

    typedef struct {
        logic              port;
        logic [DATA_W-1:0] rdata;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic poke(input logic [3:0] idx, input logic [DATA_W-1:0] data);
        poke_idx  = idx;
        poke_data = data;
        poke_en   = 1'b1;
        tick();
        poke_en   = 1'b0;
    endtask

    // Issue one transaction, hold it until its ACK, then release and return to IDLE.
    task automatic run_txn(input logic port, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata);
        int n;
        logic ack;
        if (port) begin REQ1 = 1'b1; WE1 = we; ADDR1 = addr; WDATA1 = wdata; end
        else      begin REQ0 = 1'b1; WE0 = we; ADDR0 = addr; WDATA0 = wdata; end
        n = 0;
        do begin
            tick();
            n++;
            ack = port ? ACK1 : ACK0;
        end while (!ack && n < 10);
        check("txn_ack_seen", 64'(ack), 64'(1));
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        tick();
    endtask

    // ACK monitor: exclusivity, expected port order and read data from the scoreboard.
    always @(negedge CLK) begin
        if (!RST && (ACK0 || ACK1)) begin
            check("ack_exclusive", 64'(ACK0 & ACK1), 64'(0));
            if (sb.size() == 0) begin
                check("unexpected_ack", 64'({ACK0, ACK1}), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_port", 64'(ACK1), 64'(e.port));
                check("ack_rdata", 64'(ACK1 ? RDATA1 : RDATA0), 64'(e.rdata));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, t0, t1, n;
        logic [4:0] order;

        RST = 1'b1;
        REQ0 = 1'b0; WE0 = 1'b0; ADDR0 = '0; WDATA0 = '0;
        REQ1 = 1'b0; WE1 = 1'b0; ADDR1 = '0; WDATA1 = '0;
        tick();
        tick();
        check("reset_ctrl", 64'({ACK0, ACK1, M_WE, BUSY}), 64'(0));
        check("reset_m_addr", 64'(M_ADDR), 64'(0));
        check("reset_m_din", 64'(M_DIN), 64'(0));
        check("reset_rdata", 64'({RDATA0, RDATA1}), 64'(0));
        RST = 1'b0;
        tick();
        poke(4'd2, 32'h0000_0011);
        poke(4'd4, 32'hDEAD_BEEF);

        // Reset during ACCESS abandons the port-1 write.
        REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 32'h8; WDATA1 = 32'h55;
        tick();
        check("t1_access_we", 64'(M_WE), 64'(1));
        check("t1_access_addr", 64'(M_ADDR), 64'(32'h8));
        check("t1_access_din", 64'(M_DIN), 64'(32'h55));
        #2;
        RST = 1'b1;
        #1;
        check("t1_rst_drop", 64'({M_WE, BUSY, ACK1}), 64'(0));
        REQ1 = 1'b0; WE1 = 1'b0;
        tick();
        check("t1_mem_kept", 64'(mem[2]), 64'(32'h11));
        check("t1_no_ack", 64'({ACK0, ACK1, BUSY}), 64'(0));
        RST = 1'b0;
        tick();

        // Port-0 read with cycle-exact latency.
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 32'h10;
        sb.push_back('{port: 1'b0, rdata: 32'hDEAD_BEEF});
        tick();
        check("t2_access_addr", 64'(M_ADDR), 64'(32'h10));
        check("t2_access_ctrl", 64'({M_WE, BUSY, ACK0}), 64'(3'b010));
        tick();
        check("t2_ack0", 64'({ACK0, ACK1}), 64'(2'b10));
        check("t2_rdata0", 64'(RDATA0), 64'(32'hDEAD_BEEF));
        REQ0 = 1'b0;
        tick();
        check("t2_after", 64'({ACK0, BUSY}), 64'(0));
        check("t2_rdata0_held", 64'(RDATA0), 64'(32'hDEAD_BEEF));

        // Port-1 write then port-0 read of the same word.
        sb.push_back('{port: 1'b1, rdata: 32'h0});
        run_txn(1'b1, 1'b1, 32'h8, 32'h8);
        check("t3_mem_written", 64'(mem[2]), 64'(32'h8));
        sb.push_back('{port: 1'b0, rdata: 32'h8});
        run_txn(1'b0, 1'b0, 32'h8, 32'h0);
        check("t3_rdata0", 64'(RDATA0), 64'(32'h8));
        check("t3_rdata1_kept", 64'(RDATA1), 64'(32'h0));

        // Simultaneous requests: port 1 first, port 0 three cycles later.
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 32'h10;
        REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 32'h8;
        sb.push_back('{port: 1'b1, rdata: 32'h8});
        sb.push_back('{port: 1'b0, rdata: 32'hDEAD_BEEF});
        t0 = -1; t1 = -1; cyc = 0;
        while (t0 < 0 && cyc < 20) begin
            tick();
            cyc++;
            if (ACK1) begin t1 = cyc; REQ1 = 1'b0; end
            if (ACK0) begin t0 = cyc; REQ0 = 1'b0; end
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        check("t4_ack1_cycle", 64'(t1), 64'(2));
        check("t4_ack0_cycle", 64'(t0), 64'(5));
        tick();

        // Starvation guard: four port-1 grants, then port 0 on the fifth arbitration.
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 32'h8;
        REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 32'h10;
        for (int i = 0; i < 4; i++) sb.push_back('{port: 1'b1, rdata: 32'hDEAD_BEEF});
        sb.push_back('{port: 1'b0, rdata: 32'h8});
        n = 0; cyc = 0; order = '0;
        while (n < 5 && cyc < 40) begin
            tick();
            cyc++;
            if (ACK0 || ACK1) begin
                order = {order[3:0], ACK1};
                n++;
                if (n == 5) begin REQ0 = 1'b0; REQ1 = 1'b0; end
            end
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        check("t5_grant_count", 64'(n), 64'(5));
        check("t5_grant_order", 64'(order), 64'(5'b11110));
        tick();
        check("t5_starve_cleared", 64'(dut.starve_q), 64'(0));

        // Idle: nothing moves.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t6_idle", 64'({M_WE, BUSY, ACK0, ACK1}), 64'(0));
        end

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
